// File: rtl/gpu_sprite_engine.sv
// XOR sprite drawer for a byte-packed 1bpp framebuffer in shared memory.
// Handles 8x(1..15) and 16x16 sprites, wrap/clip at screen edges, full-screen clear and collision counting.
module gpu_sprite_engine #(
   parameter int unsigned SCREEN_W_BYTES = 8,
   parameter int unsigned SCREEN_H       = 32,
   parameter int unsigned FB_BASE        = 12'h100,
   parameter int unsigned ADDR_W         = 12,
   localparam int unsigned XW = $clog2(SCREEN_W_BYTES * 8),
   localparam int unsigned YW = $clog2(SCREEN_H)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              draw,
   input  logic              clear,
   input  logic              wide,
   input  logic              clip,
   input  logic [ADDR_W-1:0] addr,
   input  logic [3:0]        lines,
   input  logic [XW-1:0]     x,
   input  logic [YW-1:0]     y,
   output logic              busy,
   output logic              collision,
   output logic [4:0]        collision_rows,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_read_idx,
   input  logic [7:0]        mem_read_byte,
   input  logic              mem_read_ack,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_write_idx,
   output logic [7:0]        mem_write_byte
);
   localparam int unsigned CW  = $clog2(SCREEN_W_BYTES);
   localparam int unsigned NB  = SCREEN_W_BYTES * SCREEN_H;
   localparam int unsigned CLW = $clog2(NB);
   localparam int unsigned RSW = YW + 5;

   typedef enum logic [2:0] {
      IDLE, CLEAR, LOAD_SPRITE, LOAD_SPRITE_LO, LOAD_SCREEN, STORE_SCREEN, NEXT_ROW
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [4:0]        nrows;
      logic [XW-1:0]     x;
      logic [YW-1:0]     y;
      logic              wide;
      logic              clip;
   } draw_req_t;

   state_t            state_q, state_d;
   draw_req_t         req_q;
   logic [4:0]        row_q;
   logic [1:0]        col_q;
   logic [7:0]        hi_q;
   logic [23:0]       word_q;
   logic [7:0]        wbyte_q;
   logic              row_coll_q;
   logic [CLW-1:0]    clr_q;

   logic [4:0]        start_nrows;
   logic [2:0]        xs;
   logic [CW-1:0]     xcol;
   logic [CW:0]       col_sum, col_sum_nx;
   logic [RSW-1:0]    row_sum, row_sum_nx;
   logic [1:0]        last_c;
   logic              last_col, last_row;
   logic [4:0]        row_nx;
   logic [ADDR_W-1:0] scr_addr, spr_addr, spr_lo_addr, clr_addr;
   logic [7:0]        spr_byte;
   logic              coll_now;

   assign busy        = (state_q != IDLE);
   assign start_nrows = (wide && lines == 4'd0) ? 5'd16 : {1'b0, lines};
   assign xs          = req_q.x[2:0];
   assign xcol        = req_q.x[XW-1:3];

   // Column and row sums keep a carry bit so clip mode can spot the edge before wrapping.
   assign col_sum    = {1'b0, xcol} + (CW+1)'(col_q);
   assign col_sum_nx = col_sum + (CW+1)'(1);
   assign row_sum    = RSW'(req_q.y) + RSW'(row_q);
   assign row_sum_nx = row_sum + RSW'(1);
   assign row_nx     = row_q + 5'd1;

   assign last_c   = {1'b0, req_q.wide} + {1'b0, (xs != 3'd0)};
   assign last_col = (col_q == last_c) ||
                     (req_q.clip && (col_sum_nx >= (CW+1)'(SCREEN_W_BYTES)));
   assign last_row = (row_nx == req_q.nrows) ||
                     (req_q.clip && (row_sum_nx >= RSW'(SCREEN_H)));

   assign scr_addr    = ADDR_W'(FB_BASE) + ADDR_W'({row_sum[YW-1:0], col_sum[CW-1:0]});
   assign spr_addr    = req_q.addr + (req_q.wide ? ADDR_W'({row_q, 1'b0}) : ADDR_W'(row_q));
   assign spr_lo_addr = req_q.addr + ADDR_W'({row_q, 1'b1});
   assign clr_addr    = ADDR_W'(FB_BASE) + ADDR_W'(clr_q);

   always_comb begin
      case (col_q)
         2'd0:    spr_byte = word_q[23:16];
         2'd1:    spr_byte = word_q[15:8];
         default: spr_byte = word_q[7:0];
      endcase
   end

   assign coll_now = |(mem_read_byte & spr_byte);

   // Next state and memory strobes; mem_* are purely a function of the current state.
   always_comb begin
      state_d        = state_q;
      mem_read       = 1'b0;
      mem_read_idx   = '0;
      mem_write      = 1'b0;
      mem_write_idx  = '0;
      mem_write_byte = '0;
      case (state_q)
         IDLE: begin
            if (clear)     state_d = CLEAR;
            else if (draw) state_d = (start_nrows == 5'd0) ? NEXT_ROW : LOAD_SPRITE;
         end
         CLEAR: begin
            mem_write     = 1'b1;
            mem_write_idx = clr_addr;
            if (clr_q == CLW'(NB - 1)) state_d = IDLE;
         end
         LOAD_SPRITE: begin
            mem_read     = 1'b1;
            mem_read_idx = spr_addr;
            if (mem_read_ack) state_d = req_q.wide ? LOAD_SPRITE_LO : LOAD_SCREEN;
         end
         LOAD_SPRITE_LO: begin
            mem_read     = 1'b1;
            mem_read_idx = spr_lo_addr;
            if (mem_read_ack) state_d = LOAD_SCREEN;
         end
         LOAD_SCREEN: begin
            mem_read     = 1'b1;
            mem_read_idx = scr_addr;
            if (mem_read_ack) state_d = STORE_SCREEN;
         end
         STORE_SCREEN: begin
            mem_write      = 1'b1;
            mem_write_idx  = scr_addr;
            mem_write_byte = wbyte_q;
            // Row advance is folded in here so a steady-state row costs no extra cycle.
            if (!last_col)     state_d = LOAD_SCREEN;
            else if (last_row) state_d = IDLE;
            else               state_d = LOAD_SPRITE;
         end
         NEXT_ROW: begin
            if (req_q.nrows == 5'd0 || last_row) state_d = IDLE;
            else                                 state_d = LOAD_SPRITE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         req_q          <= '0;
         row_q          <= '0;
         col_q          <= '0;
         hi_q           <= '0;
         word_q         <= '0;
         wbyte_q        <= '0;
         row_coll_q     <= 1'b0;
         clr_q          <= '0;
         collision      <= 1'b0;
         collision_rows <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (clear) begin
                  clr_q          <= '0;
                  collision      <= 1'b0;
                  collision_rows <= '0;
               end else if (draw) begin
                  req_q.addr     <= addr;
                  req_q.nrows    <= start_nrows;
                  req_q.x        <= x;
                  req_q.y        <= y;
                  req_q.wide     <= wide;
                  req_q.clip     <= clip;
                  row_q          <= '0;
                  col_q          <= '0;
                  row_coll_q     <= 1'b0;
                  collision      <= 1'b0;
                  collision_rows <= '0;
               end
            end
            CLEAR: clr_q <= clr_q + CLW'(1);
            LOAD_SPRITE: begin
               if (mem_read_ack) begin
                  if (req_q.wide) hi_q   <= mem_read_byte;
                  else            word_q <= {mem_read_byte, 16'h0000} >> xs;
               end
            end
            LOAD_SPRITE_LO: begin
               if (mem_read_ack) word_q <= {hi_q, mem_read_byte, 8'h00} >> xs;
            end
            LOAD_SCREEN: begin
               if (mem_read_ack) begin
                  wbyte_q <= mem_read_byte ^ spr_byte;
                  if (coll_now) begin
                     collision  <= 1'b1;
                     row_coll_q <= 1'b1;
                  end
               end
            end
            STORE_SCREEN: begin
               if (!last_col) begin
                  col_q <= col_q + 2'd1;
               end else begin
                  col_q      <= '0;
                  row_q      <= row_nx;
                  row_coll_q <= 1'b0;
                  if (row_coll_q && collision_rows != 5'd31)
                     collision_rows <= collision_rows + 5'd1;
               end
            end
            NEXT_ROW: row_q <= row_nx;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_gpu_sprite_engine.sv
// Bench for gpu_sprite_engine: memory responder with variable ack latency, pixel-level
// reference model of the XOR draw, directed edge cases plus randomized draws.
module tb_gpu_sprite_engine;
   localparam int W = 8;
   localparam int H = 32;

   logic        clk = 1'b0;
   logic        reset_n, draw, clear, wide, clip;
   logic [11:0] addr;
   logic [3:0]  lines;
   logic [5:0]  x;
   logic [4:0]  y;
   logic        busy, collision;
   logic [4:0]  collision_rows;
   logic        mem_read, mem_read_ack, mem_write;
   logic [11:0] mem_read_idx, mem_write_idx;
   logic [7:0]  mem_read_byte, mem_write_byte;

   gpu_sprite_engine #(.SCREEN_W_BYTES(W), .SCREEN_H(H), .FB_BASE(12'h100), .ADDR_W(12)) dut (
      .clk(clk), .reset_n(reset_n), .draw(draw), .clear(clear), .wide(wide), .clip(clip),
      .addr(addr), .lines(lines), .x(x), .y(y), .busy(busy), .collision(collision),
      .collision_rows(collision_rows), .mem_read(mem_read), .mem_read_idx(mem_read_idx),
      .mem_read_byte(mem_read_byte), .mem_read_ack(mem_read_ack), .mem_write(mem_write),
      .mem_write_idx(mem_write_idx), .mem_write_byte(mem_write_byte));

   always #5 clk = ~clk;

   // mem is the image the DUT reads; it is refreshed from the model after each draw
   // (no draw ever re-reads a byte it has written).
   logic [7:0]  mem [0:4095];
   logic [7:0]  ref_mem [0:4095];
   logic [19:0] wlog [$];
   logic [19:0] expq [$];
   int          lat_max;
   int          wait_cnt;
   int          n_assert = 0;
   int          n_fail = 0;
   int          last_base;

   always @(posedge clk) begin
      mem_read_ack <= 1'b0;
      if (mem_write) wlog.push_back({mem_write_idx, mem_write_byte});
      if (reset_n && mem_read && !mem_read_ack) begin
         if (wait_cnt == 0) begin
            mem_read_byte <= mem[mem_read_idx];
            mem_read_ack  <= 1'b1;
            wait_cnt      <= $urandom_range(lat_max, 0);
         end else begin
            wait_cnt <= wait_cnt - 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_assert++;
      assert (got === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
      end
   endtask

   task automatic poke(input int a, input logic [7:0] d);
      mem[a] = d;
      ref_mem[a] = d;
   endtask

   // Pixel-level model: each screen bit takes sprite pixel (screen_px - x) if inside the sprite.
   task automatic model_draw(input logic [11:0] a, input logic [3:0] l, input int xx, input int yy,
                             input logic w, input logic c, output int ecoll, output int erows);
      int nr, width, ncols;
      nr    = (w && l == 4'd0) ? 16 : int'(l);
      width = w ? 16 : 8;
      ncols = (w ? 2 : 1) + (((xx % 8) != 0) ? 1 : 0);
      ecoll = 0;
      erows = 0;
      expq.delete();
      for (int r = 0; r < nr; r++) begin
         int row;
         logic [15:0] sp;
         bit rc;
         row = yy + r;
         if (row >= H) begin
            if (c) break;
            row = row % H;
         end
         if (w) sp = {ref_mem[int'(a) + 2*r], ref_mem[int'(a) + 2*r + 1]};
         else   sp = {ref_mem[int'(a) + r], 8'h00};
         rc = 0;
         for (int cc = 0; cc < ncols; cc++) begin
            int col, ad;
            logic [7:0] s, old;
            col = xx / 8 + cc;
            if (col >= W) begin
               if (c) continue;
               col = col % W;
            end
            s = 8'h00;
            for (int b = 0; b < 8; b++) begin
               int p;
               p = (xx / 8 + cc) * 8 + (7 - b) - xx;
               if (p >= 0 && p < width) s[b] = sp[15 - p];
            end
            ad  = 'h100 + row * W + col;
            old = ref_mem[ad];
            if ((old & s) != 8'h00) rc = 1;
            ref_mem[ad] = old ^ s;
            expq.push_back({ad[11:0], old ^ s});
         end
         if (rc) begin
            ecoll = 1;
            if (erows < 31) erows++;
         end
      end
   endtask

   task automatic run_draw(input string tag, input logic [11:0] a, input logic [3:0] l, input int xx,
                           input int yy, input logic w, input logic c, input int exp_busy);
      int ecoll, erows, base, cyc;
      model_draw(a, l, xx, yy, w, c, ecoll, erows);
      base = wlog.size();
      last_base = base;
      addr = a; lines = l; x = 6'(xx); y = 5'(yy); wide = w; clip = c; draw = 1'b1;
      @(negedge clk);
      draw = 1'b0;
      cyc = 0;
      while (busy && cyc < 3000) begin
         cyc++;
         @(negedge clk);
      end
      chk({tag, "_done"}, busy, 0);
      if (exp_busy >= 0) chk({tag, "_busy_cycles"}, cyc, exp_busy);
      chk({tag, "_nwrites"}, wlog.size() - base, expq.size());
      for (int i = 0; i < expq.size(); i++)
         if (base + i < wlog.size()) chk({tag, "_write"}, wlog[base + i], expq[i]);
      chk({tag, "_collision"}, collision, ecoll);
      chk({tag, "_coll_rows"}, collision_rows, erows);
      for (int i = 'h100; i < 'h200; i++) mem[i] = ref_mem[i];
   endtask

   initial begin
      int base, cyc, strobes;
      logic [19:0] wv;
      reset_n = 1'b0; draw = 1'b0; clear = 1'b0; wide = 1'b0; clip = 1'b0;
      addr = '0; lines = '0; x = '0; y = '0;
      lat_max = 0;
      for (int i = 0; i < 4096; i++) poke(i, 8'h00);
      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_collision", collision, 0);
      chk("reset_coll_rows", collision_rows, 0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_mem_read", mem_read, 0);
      chk("idle_mem_write", mem_write, 0);

      // Basic draw, then the same draw erasing it.
      poke('h200, 8'hF0);
      run_draw("first", 12'h200, 4'd1, 0, 0, 1'b0, 1'b0, 5);
      chk("first_write_const", wlog[last_base], 20'h100F0);
      run_draw("redraw", 12'h200, 4'd1, 0, 0, 1'b0, 1'b0, 5);
      chk("redraw_write_const", wlog[last_base], 20'h10000);
      chk("redraw_collision_const", collision, 1);
      chk("redraw_rows_const", collision_rows, 1);

      // Unaligned narrow: two columns, ascending.
      poke('h210, 8'hFF);
      run_draw("unaligned", 12'h210, 4'd1, 4, 2, 1'b0, 1'b0, 8);
      chk("unaligned_col0", wlog[last_base], 20'h1100F);
      chk("unaligned_col1", wlog[last_base + 1], 20'h111F0);

      // Wide 16-row sprite at the right edge: wrap then clip.
      for (int i = 0; i < 32; i++) poke('h220 + i, 8'hFF);
      run_draw("wide_wrap", 12'h220, 4'd0, 60, 0, 1'b1, 1'b0, 208);
      run_draw("wide_clip", 12'h220, 4'd0, 60, 0, 1'b1, 1'b1, 112);

      // Bottom edge: wrap visits rows 31,0,1; clip stops after row 31.
      poke('h240, 8'h81); poke('h241, 8'h42); poke('h242, 8'h24);
      run_draw("bottom_wrap", 12'h240, 4'd3, 8, 31, 1'b0, 1'b0, 15);
      wv = wlog[last_base];     chk("bottom_wrap_row31", wv[19:8], 12'h1F9);
      wv = wlog[last_base + 1]; chk("bottom_wrap_row0", wv[19:8], 12'h101);
      wv = wlog[last_base + 2]; chk("bottom_wrap_row1", wv[19:8], 12'h109);
      run_draw("bottom_clip", 12'h240, 4'd3, 8, 31, 1'b0, 1'b1, 5);

      // Zero-row narrow draw: one busy cycle, no memory traffic.
      run_draw("zero_rows", 12'h240, 4'd0, 8, 3, 1'b0, 1'b0, 1);

      // Randomized draws over a random screen with random ack latency.
      lat_max = 2;
      for (int i = 'h100; i < 'h300; i++) poke(i, 8'($urandom));
      for (int t = 0; t < 25; t++)
         run_draw("rand", 12'h200 + 12'($urandom_range('hC0, 0)), 4'($urandom), int'($urandom_range(63, 0)),
                  int'($urandom_range(31, 0)), 1'($urandom), 1'($urandom), -1);

      // Leave a collision standing, then clear with draw asserted alongside.
      lat_max = 0;
      run_draw("pre_clear_a", 12'h200, 4'd4, 0, 0, 1'b0, 1'b0, -1);
      run_draw("pre_clear_b", 12'h200, 4'd4, 0, 0, 1'b0, 1'b0, -1);
      base = wlog.size();
      clear = 1'b1; draw = 1'b1;
      @(negedge clk);
      clear = 1'b0; draw = 1'b0;
      cyc = 0;
      while (busy && cyc < 3000) begin
         cyc++;
         @(negedge clk);
      end
      chk("clear_busy_cycles", cyc, 256);
      chk("clear_nwrites", wlog.size() - base, 256);
      for (int i = 0; i < 256; i++)
         if (base + i < wlog.size()) chk("clear_write", wlog[base + i], {12'(12'h100 + i), 8'h00});
      chk("clear_collision", collision, 0);
      chk("clear_coll_rows", collision_rows, 0);
      for (int i = 'h100; i < 'h200; i++) poke(i, 8'h00);

      // Reset in the middle of a multi-row draw.
      addr = 12'h200; lines = 4'd8; x = 6'd0; y = 5'd0; wide = 1'b0; clip = 1'b0; draw = 1'b1;
      @(negedge clk);
      draw = 1'b0;
      repeat (7) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("midreset_busy", busy, 0);
      chk("midreset_mem_read", mem_read, 0);
      chk("midreset_mem_write", mem_write, 0);
      reset_n = 1'b1;
      base = wlog.size();
      strobes = 0;
      repeat (10) begin
         @(negedge clk);
         if (mem_read || mem_write || busy) strobes++;
      end
      chk("midreset_quiet", strobes, 0);
      chk("midreset_no_writes", wlog.size() - base, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/gpu_sprite_engine.md
Name: gpu_sprite_engine

Overview:
- Parametrised successor to the CHIP-8 sprite drawer: XOR-draws sprites into a byte-packed 1bpp framebuffer in shared memory.
- Adds configurable screen size and 16x16 "wide" sprites (SCHIP).
- Adds per-draw wrap or clip mode at screen edges, a full-screen clear command, and a count of collided rows.
- Sits between the CPU core (issues draw/clear, waits on busy) and the shared memory arbiter.

Parameters:
- SCREEN_W_BYTES, 8, framebuffer row width in bytes (power of two; 8 = 64 px, 16 = 128 px)
- SCREEN_H, 32, framebuffer height in rows (power of two)
- FB_BASE, 12'h100, memory address of framebuffer byte (row 0, col 0)
- ADDR_W, 12, memory address width
- Derived: XW = clog2(SCREEN_W_BYTES*8), YW = clog2(SCREEN_H)

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- draw  in  1  start sprite draw (sampled only in IDLE)
- clear  in  1  start screen clear (sampled only in IDLE; wins over draw)
- wide  in  1  1 = 16x16 sprite, 2 bytes per row, big-endian
- clip  in  1  1 = clip at right/bottom edges, 0 = wrap
- addr  in  ADDR_W  sprite data address
- lines  in  4  sprite rows; in wide mode 0 means 16
- x  in  XW  pixel column
- y  in  YW  pixel row
- busy  out  1  high whenever state != IDLE
- collision  out  1  any set pixel cleared by the last draw
- collision_rows  out  5  rows of last draw with at least one collision
- mem_read  out  1  read request, held while !mem_read_ack
- mem_read_idx  out  ADDR_W  read address
- mem_read_byte  in  8  read data, valid in the mem_read_ack cycle
- mem_read_ack  in  1  read completion, at least 1 cycle after request
- mem_write  out  1  single-cycle write strobe
- mem_write_idx  out  ADDR_W  write address
- mem_write_byte  out  8  write data

Behaviour:
- Reset (reset_n low at a clk edge):
  - Enters IDLE; collision = 0, collision_rows = 0.
  - Takes effect mid-operation: no further reads or writes; already-written bytes stay as written.
  - mem_* outputs are combinational from state and are 0 in IDLE.
- Start:
  - In IDLE, clear = 1 enters CLEAR. Otherwise draw = 1 latches addr, lines, x, y, wide and clip, clears collision and collision_rows, and enters LOAD_SPRITE.
  - draw or clear while busy is ignored.
  - Row count: nrows = (wide && lines == 0) ? 16 : lines. If nrows == 0, busy stays high for exactly 1 cycle, with no memory access.
- States: IDLE, CLEAR, LOAD_SPRITE, LOAD_SPRITE_LO, LOAD_SCREEN, STORE_SCREEN, NEXT_ROW.
- LOAD_SPRITE / LOAD_SPRITE_LO:
  - Read sprite byte(s) for the current row: narrow row r at addr+r; wide row r at addr+2r (hi) and addr+2r+1 (lo).
  - Form a 24-bit word {hi, lo_or_0, 8'b0} >> (x mod 8).
- Column bytes per row: ncols = (wide ? 2 : 1) + (x mod 8 != 0). Column c (0..ncols-1) uses word byte [23-8c -: 8].
- Addressing:
  - Screen column = x/8 + c; screen row = y + r.
  - Wrap mode: both are taken modulo SCREEN_W_BYTES and SCREEN_H.
  - Clip mode: columns >= SCREEN_W_BYTES are skipped (no read, no write). Reaching a row >= SCREEN_H ends the draw and returns to IDLE.
  - Byte address = FB_BASE + row*SCREEN_W_BYTES + col, truncated to ADDR_W.
- LOAD_SCREEN / STORE_SCREEN:
  - LOAD_SCREEN holds mem_read until ack.
  - On ack: latch old ^ spr, and evaluate collision |(old & spr).
  - STORE_SCREEN asserts mem_write for exactly one cycle, in the cycle immediately after the ack.
  - Every in-range column is written, even when spr == 0.
  - Columns are processed in ascending c.
- Collision accounting:
  - Any column collision sets collision.
  - collision_rows increments once per row with a collision, saturating at 31. Clipped rows are not counted.
- NEXT_ROW: returns to IDLE after nrows rows; otherwise goes to LOAD_SPRITE for r+1.
- Timing: with an ack latency of 1 cycle, a narrow aligned row takes 5 cycles.
- CLEAR:
  - Writes 0 to FB_BASE .. FB_BASE + SCREEN_W_BYTES*SCREEN_H - 1, one byte per cycle, in ascending order, with no reads.
  - Clears collision and collision_rows.
  - busy is high for exactly SCREEN_W_BYTES*SCREEN_H cycles.
- Start coordinates: out-of-range inputs cannot occur, since x and y are XW and YW bits wide.

Test Plan:
- Defaults; sprite [0x200] = F0; draw x=0, y=0, lines=1, screen zero -> one write [0x100]=F0; collision=0, collision_rows=0; busy falls after the write.
- Same draw repeated -> [0x100]=00; collision=1, collision_rows=1.
- Narrow draw x=4, y=2, byte FF -> [0x110]=0F, then [0x111]=F0, in that order.
- Wide draw x=60, y=0, lines=0, bytes FF,FF in wrap mode -> per row writes to col 7 (0F), col 0 (FF), col 1 (F0), 16 rows. Same draw in clip mode -> only col 7 written per row.
- Narrow draw y=31, lines=3: wrap mode -> rows 31, 0, 1 written. Clip mode -> only row 31 written; busy drops after the row-31 write.
- clear and draw together in IDLE -> 256 zero writes 0x100..0x1FF, busy for 256 cycles, draw ignored. reset_n low mid-draw -> next cycle IDLE, no further mem strobes.
